// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake.
// Single-cycle ops finish on accept; MUL is an iterative shift-add.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    prod;
  logic             accept;
  logic             is_mul;
  logic             last;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (opcode == 3'b110);
  assign last      = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = is_mul ? BUSY : DONE;
      BUSY: if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Single-cycle ops evaluate straight from the accepted operands
  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] r_c;
  logic             c_c, o_c, e_c, z_c;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    dif = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    r_c = '0;
    c_c = 1'b0;
    o_c = 1'b0;
    e_c = 1'b0;
    unique case (opcode)
      3'b000: begin
        r_c = sum[WIDTH-1:0];
        c_c = sum[WIDTH];
        o_c = (a[WIDTH-1] == b[WIDTH-1]) &&
              (sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        r_c = dif[WIDTH-1:0];
        c_c = dif[WIDTH];
        o_c = (a[WIDTH-1] != b[WIDTH-1]) &&
              (dif[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: r_c = a & b;
      3'b011: r_c = a | b;
      3'b100: r_c = a ^ b;
      3'b101: r_c = {{(WIDTH-1){1'b0}},
                     ($signed(a) < $signed(b))};
      3'b111: e_c = 1'b1;
      default: r_c = '0;
    endcase
    z_c = (r_c == '0);
  end

  // One partial product per edge; step 0 happens on the accept edge
  always_comb begin
    pp = '0;
    if (b_q[cnt]) pp = {{WIDTH{1'b0}}, a_q} << cnt;
    prod = acc + pp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      acc       <= '0;
      result    <= '0;
      result_hi <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= a;
        b_q <= b;
        if (is_mul) begin
          acc <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
          cnt <= CW'(1);
        end else begin
          result    <= r_c;
          result_hi <= '0;
          cout      <= c_c;
          zero      <= z_c;
          neg       <= r_c[WIDTH-1];
          ovf       <= o_c;
          err       <= e_c;
        end
      end else if (state == BUSY) begin
        acc <= prod;
        if (last) begin
          cnt       <= '0;
          result    <= prod[WIDTH-1:0];
          result_hi <= prod[PW-1:WIDTH];
          cout      <= (prod[PW-1:WIDTH] != '0);
          zero      <= (prod[WIDTH-1:0] == '0);
          neg       <= prod[WIDTH-1];
          ovf       <= 1'b0;
          err       <= 1'b0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule
